// File: rtl/dec_cfg_loader_if.sv
// Boot-ROM, host write port and decoder config bus for dec_cfg_loader.
// master = the loader, slave = ROM / host / decoder side.
interface dec_cfg_loader_if #(
  parameter int ROM_AW = 5,
  parameter int CFG_AW = 8
);
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              io_busy;
  logic              host_req;
  logic [CFG_AW-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic              host_err;
  logic              cfg_we;
  logic [CFG_AW-1:0] cfg_addr;
  logic [7:0]        cfg_wdata;
  logic              boot_done;
  logic              boot_err;

  modport master (
    output rom_addr, host_ack, host_err, cfg_we, cfg_addr, cfg_wdata, boot_done, boot_err,
    input  rom_data, io_busy, host_req, host_addr, host_wdata
  );

  modport slave (
    input  rom_addr, host_ack, host_err, cfg_we, cfg_addr, cfg_wdata, boot_done, boot_err,
    output rom_data, io_busy, host_req, host_addr, host_wdata
  );
endinterface

// File: rtl/dec_cfg_loader.sv
// Streams the boot table onto the decoder config bus, then serves host writes.
// Optional DEC_CFG_LOADER_HOLDOFF_EN: stall config writes while io_busy is high.
module dec_cfg_loader #(
  parameter int                TABLE_DEPTH  = 13,
  parameter int                ROM_AW       = 5,
  parameter int                CFG_AW       = 8,
  parameter logic [CFG_AW-1:0] IRQ_CFG_BASE = 8'hC0,
  parameter logic [7:0]        END_MARK     = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  dec_cfg_loader_if.master bus
);
  typedef enum logic [2:0] {FETCH, CHECK, WRITE, GAP, IDLE, HCHECK, REJECT} state_t;

  state_t            state_reg;
  logic [ROM_AW-1:0] rom_addr_reg;
  logic              cfg_we_reg;
  logic [CFG_AW-1:0] cfg_addr_reg;
  logic [7:0]        cfg_wdata_reg;
  logic              host_ack_reg;
  logic              host_err_reg;
  logic              boot_done_reg;
  logic              boot_err_reg;

  logic              holdoff;
  logic [7:0]        entry_addr;
  logic [7:0]        entry_data;
  logic              entry_irq;
  logic [ROM_AW:0]   idx_next;

`ifdef DEC_CFG_LOADER_HOLDOFF_EN
  assign holdoff = bus.io_busy;
`else
  logic unused_io_busy;
  assign holdoff        = 1'b0;
  assign unused_io_busy = bus.io_busy;
`endif

  assign entry_addr = bus.rom_data[15:8];
  assign entry_data = bus.rom_data[7:0];
  assign entry_irq  = (CFG_AW'(entry_addr) >= IRQ_CFG_BASE);
  // rom_addr doubles as the boot index; one extra bit so DEPTH == 2^ROM_AW still terminates
  assign idx_next   = {1'b0, rom_addr_reg} + (ROM_AW+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FETCH;
      rom_addr_reg  <= '0;
      cfg_we_reg    <= 1'b0;
      cfg_addr_reg  <= '0;
      cfg_wdata_reg <= '0;
      host_ack_reg  <= 1'b0;
      host_err_reg  <= 1'b0;
      boot_done_reg <= 1'b0;
      boot_err_reg  <= 1'b0;
    end else begin
      cfg_we_reg   <= 1'b0;
      host_ack_reg <= 1'b0;
      host_err_reg <= 1'b0;
      case (state_reg)
        FETCH: state_reg <= CHECK;
        CHECK: begin
          if (entry_addr == END_MARK) begin
            boot_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (entry_irq) begin
            boot_err_reg <= 1'b1;
            state_reg    <= GAP;
          end else if (!holdoff) begin
            cfg_we_reg    <= 1'b1;
            cfg_addr_reg  <= CFG_AW'(entry_addr);
            cfg_wdata_reg <= entry_data;
            state_reg     <= WRITE;
          end
        end
        WRITE: begin
          // boot_done distinguishes a host transfer from a boot entry
          host_ack_reg <= boot_done_reg;
          state_reg    <= GAP;
        end
        GAP: begin
          if (boot_done_reg) begin
            state_reg <= IDLE;
          end else if (idx_next == (ROM_AW+1)'(TABLE_DEPTH)) begin
            boot_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            rom_addr_reg <= idx_next[ROM_AW-1:0];
            state_reg    <= FETCH;
          end
        end
        IDLE: begin
          if (bus.host_req) begin
            if (bus.host_addr >= IRQ_CFG_BASE) begin
              host_ack_reg <= 1'b1;
              host_err_reg <= 1'b1;
              state_reg    <= REJECT;
            end else begin
              cfg_addr_reg  <= bus.host_addr;
              cfg_wdata_reg <= bus.host_wdata;
              state_reg     <= HCHECK;
            end
          end
        end
        HCHECK: begin
          if (!holdoff) begin
            cfg_we_reg <= 1'b1;
            state_reg  <= WRITE;
          end
        end
        REJECT:  state_reg <= IDLE;
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr_reg;
  assign bus.cfg_we    = cfg_we_reg;
  assign bus.cfg_addr  = cfg_addr_reg;
  assign bus.cfg_wdata = cfg_wdata_reg;
  assign bus.host_ack  = host_ack_reg;
  assign bus.host_err  = host_err_reg;
  assign bus.boot_done = boot_done_reg;
  assign bus.boot_err  = boot_err_reg;
endmodule

// File: tb/tb_dec_cfg_loader.sv
// Randomized bench for dec_cfg_loader: boot table walk and host writes checked
// against a cycle-timing model derived from the table rules.
module tb_dec_cfg_loader;
  localparam int TD     = 13;
  localparam int ROM_AW = 5;
  localparam int CFG_AW = 8;
`ifdef DEC_CFG_LOADER_HOLDOFF_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [15:0] rom_mem [0:31];
  bit          busy_pat [0:1023];

  dec_cfg_loader_if #(.ROM_AW(ROM_AW), .CFG_AW(CFG_AW)) bus();

  dec_cfg_loader #(.TABLE_DEPTH(TD), .ROM_AW(ROM_AW), .CFG_AW(CFG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // synchronous boot ROM: data valid one cycle after address
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic bit busy_at(input int c);
    return busy_pat[c % 1024];
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    bus.io_busy = busy_at(cyc);
  endtask

  task automatic gen_busy(input int pct);
    for (int i = 0; i < 1024; i++) busy_pat[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic load_plan_table();
    for (int k = 0; k < 32; k++) begin
      logic [7:0] d;
      d = (k == 0) ? 8'h10 : (k == 1) ? 8'hF0 : (k == 2) ? 8'h01 : 8'(k * 17);
      rom_mem[k] = {8'(k * 4), d};
    end
  endtask

  task automatic load_random_table();
    for (int k = 0; k < 32; k++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 19);
      if (r == 0)      a = 8'hFF;
      else if (r < 3)  a = 8'($urandom_range(8'hC0, 8'hFE));
      else             a = 8'($urandom_range(0, 8'hBF));
      rom_mem[k] = {a, 8'($urandom_range(0, 255))};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.io_busy    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.cfg_we",    int'(bus.cfg_we),    0);
    check_eq("rst.rom_addr",  int'(bus.rom_addr),  0);
    check_eq("rst.boot_done", int'(bus.boot_done), 0);
    check_eq("rst.boot_err",  int'(bus.boot_err),  0);
    check_eq("rst.host_ack",  int'(bus.host_ack),  0);
    rst = 1'b0;
    cyc = 0;
    bus.io_busy = busy_at(0);
  endtask

  task automatic run_boot(input string tag);
    int exp_cyc[$];
    int exp_addr[$];
    int exp_data[$];
    int obs_cyc[$];
    int obs_addr[$];
    int obs_data[$];
    int t, c, a, exp_done, exp_max, done_cyc, max_a, acks, nmin;
    bit exp_err;
    // model: each entry is FETCH, CHECK(+stalls), then WRITE+GAP or just GAP
    t = 0; exp_err = 1'b0; exp_done = -1; exp_max = 0;
    for (int k = 0; k < TD; k++) begin
      a = int'(rom_mem[k][15:8]);
      exp_max = k;
      c = t + 1;
      if (a == 'hFF) begin
        exp_done = c + 1;
        break;
      end
      if (a >= 'hC0) begin
        exp_err = 1'b1;
        t = c + 2;
        continue;
      end
      while (HOLD && busy_at(c)) c++;
      exp_cyc.push_back(c + 1);
      exp_addr.push_back(a);
      exp_data.push_back(int'(rom_mem[k][7:0]));
      t = c + 3;
    end
    if (exp_done < 0) exp_done = t;

    do_reset();
    done_cyc = -1; max_a = 0; acks = 0;
    for (int n = 0; n < 3000; n++) begin
      if (bus.cfg_we) begin
        obs_cyc.push_back(cyc);
        obs_addr.push_back(int'(bus.cfg_addr));
        obs_data.push_back(int'(bus.cfg_wdata));
        $display("%s: boot write cyc=%0d addr=%02h data=%02h", tag, cyc, bus.cfg_addr, bus.cfg_wdata);
      end
      if (bus.host_ack) acks++;
      if (int'(bus.rom_addr) > max_a) max_a = int'(bus.rom_addr);
      if (bus.boot_done) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    check_eq({tag, ".done_cyc"}, done_cyc, exp_done);
    check_eq({tag, ".n_writes"}, obs_cyc.size(), exp_cyc.size());
    nmin = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < nmin; i++) begin
      check_eq($sformatf("%s.wr%0d.cyc", tag, i),  obs_cyc[i],  exp_cyc[i]);
      check_eq($sformatf("%s.wr%0d.addr", tag, i), obs_addr[i], exp_addr[i]);
      check_eq($sformatf("%s.wr%0d.data", tag, i), obs_data[i], exp_data[i]);
    end
    check_eq({tag, ".boot_err"}, int'(bus.boot_err), int'(exp_err));
    check_eq({tag, ".max_rom_addr"}, max_a, exp_max);
    check_eq({tag, ".acks_during_boot"}, acks, 0);
  endtask

  task automatic host_txn(input string tag, input int addr, input int data);
    int t, c, exp_we, exp_ack, we_cyc, we_addr, we_data, ack_cyc, nwe;
    bit exp_err, err;
    t = cyc;
    bus.host_req   = 1'b1;
    bus.host_addr  = addr[7:0];
    bus.host_wdata = data[7:0];
    if (addr >= 'hC0) begin
      exp_err = 1'b1; exp_we = -1; exp_ack = t + 1;
    end else begin
      exp_err = 1'b0;
      c = t + 1;
      while (HOLD && busy_at(c)) c++;
      exp_we = c + 1; exp_ack = c + 2;
    end
    nwe = 0; we_cyc = -1; we_addr = -1; we_data = -1; ack_cyc = -1; err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (bus.cfg_we) begin
        nwe++;
        we_cyc = cyc; we_addr = int'(bus.cfg_addr); we_data = int'(bus.cfg_wdata);
      end
      if (bus.host_ack) begin
        ack_cyc = cyc;
        err = bus.host_err;
        break;
      end
    end
    bus.host_req = 1'b0;
    $display("%s: host addr=%02h data=%02h req@%0d we@%0d ack@%0d err=%0d", tag, addr, data, t, we_cyc, ack_cyc, err);
    check_eq({tag, ".ack_cyc"}, ack_cyc, exp_ack);
    check_eq({tag, ".err"}, int'(err), int'(exp_err));
    check_eq({tag, ".n_we"}, nwe, exp_err ? 0 : 1);
    if (!exp_err) begin
      check_eq({tag, ".we_cyc"}, we_cyc, exp_we);
      check_eq({tag, ".we_addr"}, we_addr, addr);
      check_eq({tag, ".we_data"}, we_data, data);
    end
    step();
    check_eq({tag, ".ack_width"}, int'(bus.host_ack), 0);
    check_eq({tag, ".boot_done_held"}, int'(bus.boot_done), 1);
  endtask

  task automatic run_host(input string tag, input int n_txn);
    for (int i = 0; i < n_txn; i++) begin
      int sel, addr;
      repeat ($urandom_range(0, 2)) step();
      sel = $urandom_range(0, 9);
      case (sel)
        0:       addr = 'hC0;
        1:       addr = 'hBF;
        2:       addr = 'hFF;
        3:       addr = $urandom_range('hC1, 'hFE);
        default: addr = $urandom_range(0, 'hBE);
      endcase
      host_txn($sformatf("%s%0d", tag, i), addr, $urandom_range(0, 255));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.io_busy    = 1'b0;

    load_plan_table();
    gen_busy(0);
    run_boot("boot_full");
    host_txn("host_0120", 'h01, 'h20);
    host_txn("host_c0aa", 'hC0, 'hAA);
    host_txn("host_bf5a", 'hBF, 'h5A);

    load_plan_table();
    rom_mem[3] = 16'hFF3C;
    run_boot("boot_end3");

    load_plan_table();
    rom_mem[1] = 16'hC455;
    run_boot("boot_irq1");

    load_plan_table();
    for (int c = 1; c <= 5; c++) busy_pat[c] = 1'b1;
    run_boot("boot_busy5");
    gen_busy(30);
    run_host("host_busy", 8);

    load_plan_table();
    gen_busy(0);
    do_reset();
    while (cyc < 10) step();
    check_eq("rstmid.we_before", int'(bus.cfg_we), 1);
    check_eq("rstmid.addr_before", int'(bus.cfg_addr), 8);
    #2 rst = 1'b1;
    #1;
    check_eq("rstmid.we_async", int'(bus.cfg_we), 0);
    check_eq("rstmid.rom_addr_async", int'(bus.rom_addr), 0);
    check_eq("rstmid.cfg_addr_async", int'(bus.cfg_addr), 0);
    run_boot("rstmid_reboot");

    for (int r = 0; r < 4; r++) begin
      load_random_table();
      gen_busy(25);
      run_boot($sformatf("rnd%0d_boot", r));
      run_host($sformatf("rnd%0d_host", r), 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
